// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the sync_fifo_ctl_p FIFO controller.
//   - flag-vector bit positions (FULL..UNDERRUN)
//   - depth_of(): FIFO depth for a given address width
package fifo_pkg;

  // Bit positions in the 8-bit flag vector.
  localparam int FULL     = 7;
  localparam int FMO      = 6;
  localparam int FWM      = 5;
  localparam int OVERRUN  = 4;
  localparam int EMPTY    = 3;
  localparam int EPO      = 2;
  localparam int EWM      = 1;
  localparam int UNDERRUN = 0;

  localparam int NUM_FLAGS = 8;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// fifo_flag_gen: registered level flags for the FIFO, computed from the
// next-state occupancy so they are valid the cycle after the operation.
// Ports:
//   clk_i, rst_ni   clock / asynchronous active-low reset
//   flush_i         synchronous flush; forces the reset flag values
//   cnt_d_i         next occupancy, 0..DEPTH
//   upaf_i          almost-full offset   (FWM when count >= DEPTH-upaf)
//   upae_i          almost-empty threshold (EWM when count <= upae)
//   empty_o, epo_o, ewm_o, full_o, fmo_o, fwm_o   registered level flags
module fifo_flag_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH:0]   cnt_d_i,
  input  logic [ADDR_WIDTH-1:0] upaf_i,
  input  logic [ADDR_WIDTH-1:0] upae_i,
  output logic                  empty_o,
  output logic                  epo_o,
  output logic                  ewm_o,
  output logic                  full_o,
  output logic                  fmo_o,
  output logic                  fwm_o
);

  localparam int                DEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1 = DEPTH_C - (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] fwm_thr;
  logic empty_d, epo_d, ewm_d, full_d, fmo_d, fwm_d;
  logic empty_q, epo_q, ewm_q, full_q, fmo_q, fwm_q;

  // upaf_i < DEPTH, so the threshold never underflows.
  assign fwm_thr = DEPTH_C - {1'b0, upaf_i};

  always_comb begin
    empty_d = 1'b1;
    epo_d   = 1'b0;
    ewm_d   = 1'b1;
    full_d  = 1'b0;
    fmo_d   = 1'b0;
    fwm_d   = 1'b0;
    if (!flush_i) begin
      empty_d = (cnt_d_i == '0);
      epo_d   = (cnt_d_i == (ADDR_WIDTH+1)'(1));
      ewm_d   = (cnt_d_i <= {1'b0, upae_i});
      full_d  = (cnt_d_i == DEPTH_C);
      fmo_d   = (cnt_d_i == DEPTH_M1);
      fwm_d   = (cnt_d_i >= fwm_thr);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      empty_q <= 1'b1;
      epo_q   <= 1'b0;
      ewm_q   <= 1'b1;
      full_q  <= 1'b0;
      fmo_q   <= 1'b0;
      fwm_q   <= 1'b0;
    end else begin
      empty_q <= empty_d;
      epo_q   <= epo_d;
      ewm_q   <= ewm_d;
      full_q  <= full_d;
      fmo_q   <= fmo_d;
      fwm_q   <= fwm_d;
    end
  end

  assign empty_o = empty_q;
  assign epo_o   = epo_q;
  assign ewm_o   = ewm_q;
  assign full_o  = full_q;
  assign fmo_o   = fmo_q;
  assign fwm_o   = fwm_q;

endmodule

// File: rtl/sync_fifo_ctl_p.sv
// sync_fifo_ctl_p: single-clock FIFO with register-array storage, occupancy
// counter, programmable watermarks and clearable sticky error flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// otherwise reads have one cycle of registered latency.
// Ports:
//   CLK_i, RST_ni        clock / asynchronous active-low reset
//   FLUSH_i              synchronous flush (highest priority)
//   CLR_ERR_i            clears OVERRUN_o / UNDERRUN_o
//   WEN_i, WDATA_i       write request and data
//   REN_i                read request (pop in FWFT build)
//   RDATA_o, RVALID_o    read data and its valid
//   UPAF_i, UPAE_i       almost-full offset / almost-empty threshold
//   COUNT_o              occupancy 0..DEPTH
//   EMPTY_o EPO_o EWM_o UNDERRUN_o FULL_o FMO_o FWM_o OVERRUN_o  flags
module sync_fifo_ctl_p
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK_i,
  input  logic                  RST_ni,
  input  logic                  FLUSH_i,
  input  logic                  CLR_ERR_i,
  input  logic                  WEN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  REN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  input  logic [ADDR_WIDTH-1:0] UPAF_i,
  input  logic [ADDR_WIDTH-1:0] UPAE_i,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o,
  output logic                  UNDERRUN_o,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  OVERRUN_o
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ovr_q, ovr_d, udr_q, udr_d;
  logic                  wr_acc, rd_acc;
  logic                  empty_w, epo_w, ewm_w, full_w, fmo_w, fwm_w;
  logic [NUM_FLAGS-1:0]  flg;

  always_comb begin
    flg           = '0;
    flg[FULL]     = full_w;
    flg[FMO]      = fmo_w;
    flg[FWM]      = fwm_w;
    flg[OVERRUN]  = ovr_q;
    flg[EMPTY]    = empty_w;
    flg[EPO]      = epo_w;
    flg[EWM]      = ewm_w;
    flg[UNDERRUN] = udr_q;
  end

  // Acceptance uses registered flags only; a same-cycle read does not make
  // room for a write into a full FIFO, and vice versa.
  assign wr_acc = WEN_i & ~flg[FULL]  & ~FLUSH_i;
  assign rd_acc = REN_i & ~flg[EMPTY] & ~FLUSH_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    udr_d  = udr_q;
    if (FLUSH_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovr_d  = 1'b0;
      udr_d  = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rptr_d = rptr_q + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        2'b01:   cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      // A new error in the same cycle as CLR_ERR_i keeps the flag set.
      if (CLR_ERR_i) begin
        ovr_d = 1'b0;
        udr_d = 1'b0;
      end
      if (WEN_i && flg[FULL])  ovr_d = 1'b1;
      if (REN_i && flg[EMPTY]) udr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      udr_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      udr_q  <= udr_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK_i) begin
    if (wr_acc) mem_q[wptr_q] <= WDATA_i;
  end

  fifo_flag_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_flag_gen (
    .clk_i   (CLK_i),
    .rst_ni  (RST_ni),
    .flush_i (FLUSH_i),
    .cnt_d_i (cnt_d),
    .upaf_i  (UPAF_i),
    .upae_i  (UPAE_i),
    .empty_o (empty_w),
    .epo_o   (epo_w),
    .ewm_o   (ewm_w),
    .full_o  (full_w),
    .fmo_o   (fmo_w),
    .fwm_o   (fwm_w)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; gated to zero while empty so the
  // output is defined out of reset even though storage is not.
  assign RDATA_o  = flg[EMPTY] ? '0 : mem_q[rptr_q];
  assign RVALID_o = ~flg[EMPTY];
`else
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem_q[rptr_q];
    end
  end

  assign RDATA_o  = rdata_q;
  assign RVALID_o = rvalid_q;
`endif

  assign COUNT_o    = cnt_q;
  assign EMPTY_o    = flg[EMPTY];
  assign EPO_o      = flg[EPO];
  assign EWM_o      = flg[EWM];
  assign UNDERRUN_o = flg[UNDERRUN];
  assign FULL_o     = flg[FULL];
  assign FMO_o      = flg[FMO];
  assign FWM_o      = flg[FWM];
  assign OVERRUN_o  = flg[OVERRUN];

endmodule

// File: doc/sync_fifo_ctl_p.md
Name: sync_fifo_ctl_p

Overview:
- Parametrised single-clock FIFO with internal register-array storage, occupancy counter and a full flag set.
- Flag set: EMPTY, EPO, EWM, UNDERRUN, FULL, FMO, FWM, OVERRUN.
- Successor to the fixed 1K x 18 BRAM FIFO controller. Adds:
  - generic width and depth;
  - runtime-programmable watermarks;
  - an occupancy output;
  - clearable sticky error flags.
- Sits between fabric logic and the TDP RAM wrappers wherever a synchronous FIFO is inferred.

Parameters:
- DATA_WIDTH, 18, word width in bits (>=1).
- ADDR_WIDTH, 10, depth DEPTH = 2**ADDR_WIDTH (ADDR_WIDTH >= 2).

Ports:
- CLK_i  in  1  clock, rising edge.
- RST_ni  in  1  asynchronous active-low reset.
- FLUSH_i  in  1  synchronous flush, active high.
- CLR_ERR_i  in  1  synchronous clear of OVERRUN_o/UNDERRUN_o.
- WEN_i  in  1  write request.
- WDATA_i  in  DATA_WIDTH  write data.
- REN_i  in  1  read request.
- RDATA_o  out  DATA_WIDTH  read data.
- RVALID_o  out  1  RDATA_o holds a newly popped word.
- UPAF_i  in  ADDR_WIDTH  almost-full offset.
- UPAE_i  in  ADDR_WIDTH  almost-empty threshold.
- COUNT_o  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- EMPTY_o, EPO_o, EWM_o, UNDERRUN_o  out  1 each  empty-side flags.
- FULL_o, FMO_o, FWM_o, OVERRUN_o  out  1 each  full-side flags.

Behaviour:
- Clocking and reset: one clock, CLK_i; reset RST_ni is asynchronous and active-low.
- Reset values: wptr=rptr=0, COUNT_o=0, EMPTY_o=1, EWM_o=1, RDATA_o=0, all other outputs 0. Storage contents are not reset.
- Write acceptance: wr_acc = WEN_i & ~FULL_o.
- Read acceptance: rd_acc = REN_i & ~EMPTY_o. Acceptance is judged on registered flags only, never on the same-cycle opposite operation.
- Pointers: on wr_acc, mem[wptr] <= WDATA_i and wptr <= wptr+1 (mod DEPTH). On rd_acc, rptr <= rptr+1 (mod DEPTH). Wrap-around is natural binary wrap.
- Occupancy: COUNT_o += wr_acc - rd_acc. Simultaneous accepted read and write leaves the count unchanged.
- Flags are registered, derived from the next count and valid in the cycle after the operation:
  - EMPTY = count==0; EPO = count==1; EWM = count<=UPAE_i;
  - FULL = count==DEPTH; FMO = count==DEPTH-1; FWM = count>=DEPTH-UPAF_i.
- Watermark inputs are quasi-static. A change takes effect on the next flag update, i.e. the next clock edge.
- Read data (default, no FWFT): on rd_acc, RDATA_o <= mem[rptr] and RVALID_o=1 for that cycle. RDATA_o holds its value otherwise; one-cycle read latency.
- Empty corner case: REN_i while EMPTY_o sets UNDERRUN_o (sticky). Pointers and RDATA_o are unchanged. A simultaneous write is still accepted.
- Full corner case: WEN_i while FULL_o sets OVERRUN_o (sticky). The write is dropped even if a read is accepted in the same cycle.
- CLR_ERR_i clears both sticky flags. A new error in the same cycle wins, so the flag stays 1.
- FLUSH_i has priority over everything else:
  - pointers and count go to 0 and flags take their reset values;
  - OVERRUN/UNDERRUN are cleared and RVALID_o=0;
  - RDATA_o holds; WEN_i/REN_i in that cycle are ignored.
- Reset mid-operation: asynchronous return to reset values. In-flight write data is lost.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- When defined (first-word-fall-through):
  - RDATA_o = mem[rptr] combinationally, valid whenever ~EMPTY_o;
  - RVALID_o = ~EMPTY_o;
  - REN_i acts as a pop/acknowledge;
  - a word written into an empty FIFO appears on RDATA_o one cycle after the write.
- When undefined: registered one-cycle-latency read as above.
- Flag and counter behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - flag-vector index localparams (FULL=7, FMO=6, FWM=5, OVERRUN=4, EMPTY=3, EPO=2, EWM=1, UNDERRUN=0);
  - the function depth_of(addr_width).
- Sub-module fifo_flag_gen, parametrised by ADDR_WIDTH:
  - inputs: next count, UPAF_i, UPAE_i, FLUSH_i;
  - outputs: the 6 level flags, registered.
- Sticky errors, pointers and storage stay in the top module.

Test Plan:
- Reset, ADDR_WIDTH=4, UPAE_i=2, UPAF_i=2: EMPTY=1, EWM=1, COUNT=0, all other flags 0, RDATA=0.
- Fill: write 16 words 0x00..0x0F.
  - Cycle after the 1st write: EPO=1, EMPTY=0.
  - After the 3rd write: EWM=0.
  - After the 14th write: FWM=1.
  - After the 15th write: FMO=1.
  - After the 16th write: FULL=1, COUNT=16.
- Overrun: 17th write of 0xAA while FULL -> OVERRUN=1, COUNT stays 16. Draining 16 words returns 0x00..0x0F in order with no 0xAA.
- Simultaneous read/write:
  - at count=8 with wptr near wrap: COUNT stays 8 and data order is preserved across wrap;
  - at count=0: write accepted, UNDERRUN=1, COUNT=1.
- Flush and clear: FLUSH_i at count=5 with WEN_i=1 -> next cycle COUNT=0, EMPTY=1, OVERRUN/UNDERRUN=0. CLR_ERR_i alone clears the sticky flags only.
- FWFT build: write 0x3C into empty FIFO -> next cycle RDATA=0x3C, RVALID=1 without REN_i. REN_i pops -> EMPTY=1.
